// File: rtl/sha_auth_pkg.sv
// Shared types and constants for the PMU SHA-256 authentication loader.
package sha_auth_pkg;

    localparam int unsigned SHA_WORD_W    = 32;
    localparam int unsigned SHA_NUM_WORDS = 8;
    localparam int unsigned SHA_ADDR_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_BLK,
        ST_LOAD_DIG,
        ST_INIT,
        ST_WAIT,
        ST_RESULT
    } state_e;

endpackage

// File: rtl/sha_auth_loader.sv
// Streams a message block and expected digest into the SHA wrapper, strobes init,
// waits a fixed time and reports a sticky pass/fail authentication result.
module sha_auth_loader
    import sha_auth_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 80
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [SHA_WORD_W-1:0] s_data,
    output logic                  s_ready,
    output logic                  sha_cs,
    output logic                  sha_we,
    output logic                  sha_wc,
    output logic [SHA_ADDR_W-1:0] sha_address,
    output logic [SHA_WORD_W-1:0] sha_write_data,
    input  logic                  sha_digest_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  auth_pass,
    output logic                  auth_fail
);

    localparam logic [7:0]            WAIT_LOAD = 8'(WAIT_CYCLES - 1);
    localparam logic [SHA_ADDR_W-1:0] LAST_IDX  = SHA_ADDR_W'(SHA_NUM_WORDS - 1);

    state_e                state_q, state_d;
    logic [SHA_ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]            wait_q, wait_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  wc_q, wc_d;
    logic [SHA_ADDR_W-1:0] addr_q, addr_d;
    logic [SHA_WORD_W-1:0] wdata_q, wdata_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  loading;
    logic                  hs;
    logic                  last_word;

    // Ready depends on registered state only, never on s_valid.
    assign loading   = (state_q == ST_LOAD_BLK) || (state_q == ST_LOAD_DIG);
    assign hs        = s_valid & loading;
    assign last_word = (wcnt_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wait_d  = wait_q;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        wc_d    = wc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        if (hs) begin
            we_d    = 1'b1;
            wc_d    = (state_q == ST_LOAD_BLK);
            addr_d  = wcnt_q;
            wdata_d = s_data;
            wcnt_d  = wcnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    wcnt_d  = '0;
                    state_d = ST_LOAD_BLK;
                end
            end
            ST_LOAD_BLK: begin
                if (hs && last_word) state_d = ST_LOAD_DIG;
            end
            ST_LOAD_DIG: begin
                if (hs && last_word) state_d = ST_INIT;
            end
            ST_INIT: begin
                cs_d    = 1'b1;
                wait_d  = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == 8'd0) begin
                    pass_d  = sha_digest_valid;
                    fail_d  = ~sha_digest_valid;
                    state_d = ST_RESULT;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            wait_q  <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            wc_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wait_q  <= wait_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            wc_q    <= wc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign s_ready        = loading;
    assign sha_cs         = cs_q;
    assign sha_we         = we_q;
    assign sha_wc         = wc_q;
    assign sha_address    = addr_q;
    assign sha_write_data = wdata_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_RESULT);
    assign auth_pass      = pass_q;
    assign auth_fail      = fail_q;

endmodule

// File: tb/tb_sha_auth_loader.sv
// Directed bench for sha_auth_loader with a small behavioural SHA-wrapper compare model.
module tb_sha_auth_loader;

    localparam int unsigned W   = 20;
    localparam int          LAT = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_ready;
    logic        sha_cs;
    logic        sha_we;
    logic        sha_wc;
    logic [2:0]  sha_address;
    logic [31:0] sha_write_data;
    logic        sha_digest_valid;
    logic        busy;
    logic        done;
    logic        auth_pass;
    logic        auth_fail;

    always #5 clk = ~clk;

    sha_auth_loader #(.WAIT_CYCLES(W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .sha_cs           (sha_cs),
        .sha_we           (sha_we),
        .sha_wc           (sha_wc),
        .sha_address      (sha_address),
        .sha_write_data   (sha_write_data),
        .sha_digest_valid (sha_digest_valid),
        .busy             (busy),
        .done             (done),
        .auth_pass        (auth_pass),
        .auth_fail        (auth_fail)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] blk [8];
    logic [31:0] ref_dig [8];
    logic [31:0] dig_reg [8];

    int cyc = 0;
    int cs_cnt = 0;
    int cs_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int cs_timer;
    int wq_addr [$];
    int wq_wc [$];
    int wq_cyc [$];
    logic [31:0] wq_data [$];

    always @(posedge clk) cyc++;

    function automatic logic digest_ok();
        for (int i = 0; i < 8; i++) begin
            if (dig_reg[i] !== ref_dig[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] word_at(input int i, input bit corrupt);
        logic [31:0] w;
        w = (i < 8) ? blk[i] : ref_dig[i-8];
        if (corrupt && i == 11) w = w ^ 32'h1;
        return w;
    endfunction

    // Wrapper model captures on the falling edge; compare result appears LAT cycles after init.
    always @(negedge clk) begin
        if (!reset_n) begin
            sha_digest_valid <= 1'b0;
            cs_timer <= -1;
        end else begin
            if (sha_we) begin
                wq_addr.push_back(int'(sha_address));
                wq_wc.push_back(int'(sha_wc));
                wq_data.push_back(sha_write_data);
                wq_cyc.push_back(cyc);
                if (!sha_wc) dig_reg[sha_address] <= sha_write_data;
            end
            if (sha_cs) begin
                cs_cnt++;
                cs_cyc = cyc;
                cs_timer <= LAT;
            end else if (cs_timer > 0) begin
                cs_timer <= cs_timer - 1;
            end else if (cs_timer == 0) begin
                sha_digest_valid <= digest_ok();
                cs_timer <= -1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run(input bit gaps, input bit corrupt, input bit poke, input int abort_at,
                       input bit exp_pass);
        int t0;
        int k;
        int done0;
        int delay;
        int n;
        wq_addr.delete();
        wq_wc.delete();
        wq_data.delete();
        wq_cyc.delete();
        cs_cnt = 0;
        done0 = done_cnt;
        delay = gaps ? 16 : 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;  // index of the edge that accepted start
        check("busy_after_start", 32'(busy), 1);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data = word_at(i, corrupt);
            if (poke && i == 10) start = 1'b1;
            if (i == abort_at) begin
                @(posedge clk);
                #2;
                reset_n = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 0);
                check("abort_we", 32'(sha_we), 0);
                check("abort_ready", 32'(s_ready), 0);
                s_valid = 1'b0;
                start = 1'b0;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                repeat (W + 30) @(negedge clk);
                check("abort_no_done", done_cnt, done0);
                return;
            end
            @(negedge clk);
            start = 1'b0;
        end
        s_valid = 1'b0;
        k = 0;
        while (done_cnt == done0 && k < 400) begin
            start = (poke && k == 5);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", done_cnt, done0 + 1);
        check("done_cycle", done_cyc - t0, W + 17 + delay);
        check("cs_cycle", cs_cyc - t0, 17 + delay);
        n = wq_addr.size();
        check("write_count", n, 16);
        if (n > 16) n = 16;
        for (int j = 0; j < n; j++) begin
            check($sformatf("wr%0d_addr", j), wq_addr[j], j % 8);
            check($sformatf("wr%0d_wc", j), wq_wc[j], (j < 8) ? 1 : 0);
            check($sformatf("wr%0d_data", j), wq_data[j], word_at(j, corrupt));
            check($sformatf("wr%0d_cycle", j), wq_cyc[j] - t0, gaps ? 2 * (j + 1) : j + 1);
        end
        repeat (3) @(negedge clk);
        check("cs_pulses", cs_cnt, 1);
        check("done_pulses", done_cnt, done0 + 1);
        check("auth_pass", 32'(auth_pass), 32'(exp_pass));
        check("auth_fail", 32'(auth_fail), 32'(!exp_pass));
        check("busy_after_done", 32'(busy), 0);
    endtask

    initial begin
        logic any;
        blk = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
        ref_dig = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        for (int i = 0; i < 8; i++) dig_reg[i] = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(auth_pass), 0);
        check("rst_fail", 32'(auth_fail), 0);
        check("rst_we", 32'(sha_we), 0);
        check("rst_cs", 32'(sha_cs), 0);
        check("rst_wc", 32'(sha_wc), 0);
        check("rst_addr", 32'(sha_address), 0);
        check("rst_data", sha_write_data, 0);

        reset_n = 1'b1;
        any = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any = any | s_ready | busy | done | auth_pass | auth_fail | sha_we | sha_cs
                  | sha_wc | (|sha_address) | (|sha_write_data);
        end
        check("idle_quiet", 32'(any), 0);

        run(1'b0, 1'b0, 1'b0, -1, 1'b1);  // pass path
        run(1'b0, 1'b1, 1'b0, -1, 1'b0);  // digest word 3 corrupted
        run(1'b1, 1'b0, 1'b0, -1, 1'b1);  // idle cycle before every word
        run(1'b0, 1'b0, 1'b1, -1, 1'b1);  // start pulsed in LOAD_DIG and WAIT
        run(1'b0, 1'b0, 1'b0, 12, 1'b0);  // reset at digest word 4
        run(1'b0, 1'b0, 1'b0, -1, 1'b1);  // fresh run after abort

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
